// File: rtl/binary_down_counter.sv
// Loadable WIDTH-bit down-counter/timer with terminal-count pulse.
// Supports one-shot mode, auto-reload mode and abort; reset is asynchronous and active-low.
module binary_down_counter #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             en,
  input  logic             auto_rld,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] out,
  output logic             tc,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic [WIDTH-1:0] out_d;
  logic             tc_d;
  logic             at_zero;

  assign at_zero = (out == '0);

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; stop beats start beats counting
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (stop)       state_d = S_IDLE;
        else if (start) state_d = S_RUN;
      end
      S_RUN: begin
        if (stop)                            state_d = S_IDLE;
        else if (start)                      state_d = S_RUN;
        else if (en && at_zero && !auto_rld) state_d = S_DONE;
      end
      S_DONE: begin
        if (stop)       state_d = S_IDLE;
        else if (start) state_d = S_RUN;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next values: count, reload value, terminal-count pulse
  always_comb begin
    out_d    = out;
    reload_d = reload_q;
    tc_d     = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (!stop && start) begin
          out_d    = load_val;
          reload_d = load_val;
        end
      end
      S_RUN: begin
        if (stop) begin
          out_d = out;
        end else if (start) begin
          out_d    = load_val;
          reload_d = load_val;
        end else if (en) begin
          if (!at_zero) begin
            out_d = out - WIDTH'(1);
          end else begin
            // Zero is held for one enabled cycle, so the counter never underflows
            tc_d = 1'b1;
            if (auto_rld) out_d = reload_q;
          end
        end
      end
      default: begin
        out_d = out;
      end
    endcase
  end

  // Registered datapath outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out      <= '0;
      reload_q <= '0;
      tc       <= 1'b0;
    end else begin
      out      <= out_d;
      reload_q <= reload_d;
      tc       <= tc_d;
    end
  end

  // Status flags decoded straight from the state register
  assign busy = (state_q == S_RUN);
  assign done = (state_q == S_DONE);

endmodule

// File: tb/tb_binary_down_counter.sv
// Scoreboard bench for binary_down_counter: a driver pushes model predictions,
// a monitor pops and compares them after each rising edge.
module tb_binary_down_counter;

  localparam int unsigned W = 4;

  logic         clk;
  logic         reset;
  logic         start;
  logic         stop;
  logic         en;
  logic         auto_rld;
  logic [W-1:0] load_val;
  logic [W-1:0] out;
  logic         tc;
  logic         busy;
  logic         done;

  typedef struct {
    int unsigned out;
    bit          tc;
    bit          busy;
    bit          done;
  } exp_t;

  exp_t exp_q[$];

  int unsigned n_total;
  int unsigned n_pass;

  // Reference model state: count value, reload value, and activity flags
  int unsigned m_count;
  int unsigned m_reload;
  bit          m_running;
  bit          m_finished;
  bit          m_tc;

  binary_down_counter #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .stop     (stop),
    .en       (en),
    .auto_rld (auto_rld),
    .load_val (load_val),
    .out      (out),
    .tc       (tc),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int unsigned act, input int unsigned req);
    n_total++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
  endtask

  task automatic model_reset();
    m_count    = 0;
    m_reload   = 0;
    m_running  = 1'b0;
    m_finished = 1'b0;
    m_tc       = 1'b0;
  endtask

  task automatic model_step(input bit st, input bit sp, input bit e, input bit ar,
                            input int unsigned lv);
    m_tc = 1'b0;
    if (sp) begin
      m_running  = 1'b0;
      m_finished = 1'b0;
    end else if (st) begin
      m_count    = lv;
      m_reload   = lv;
      m_running  = 1'b1;
      m_finished = 1'b0;
    end else if (m_running && e) begin
      if (m_count > 0) begin
        m_count = m_count - 1;
      end else begin
        m_tc = 1'b1;
        if (ar) begin
          m_count = m_reload;
        end else begin
          m_running  = 1'b0;
          m_finished = 1'b1;
        end
      end
    end
  endtask

  task automatic push_model();
    exp_t e;
    e.out  = m_count;
    e.tc   = m_tc;
    e.busy = m_running;
    e.done = m_finished;
    exp_q.push_back(e);
  endtask

  // One clock of normal operation; called just after a falling edge
  task automatic cycle(input bit st, input bit sp, input bit e, input bit ar,
                       input int unsigned lv);
    reset    = 1'b1;
    start    = st;
    stop     = sp;
    en       = e;
    auto_rld = ar;
    load_val = W'(lv);
    model_step(st, sp, e, ar, lv);
    push_model();
    @(negedge clk);
  endtask

  // Assert reset mid-cycle; outputs must clear without waiting for a clock
  task automatic reset_cycles(input int n);
    reset = 1'b0;
    #1;
    check("async_out",  32'(out),  0);
    check("async_tc",   32'(tc),   0);
    check("async_busy", 32'(busy), 0);
    check("async_done", 32'(done), 0);
    model_reset();
    for (int i = 0; i < n; i++) begin
      start    = 1'($urandom_range(0, 1));
      en       = 1'($urandom_range(0, 1));
      stop     = 1'b0;
      auto_rld = 1'($urandom_range(0, 1));
      load_val = W'($urandom_range(0, 15));
      push_model();
      @(negedge clk);
    end
    reset = 1'b1;
  endtask

  // Monitor: compare DUT against the oldest prediction after every rising edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("out",  32'(out),  e.out);
        check("tc",   32'(tc),   32'(e.tc));
        check("busy", 32'(busy), 32'(e.busy));
        check("done", 32'(done), 32'(e.done));
      end
    end
  end

  initial begin
    n_total  = 0;
    n_pass   = 0;
    reset    = 1'b0;
    start    = 1'b0;
    stop     = 1'b0;
    en       = 1'b0;
    auto_rld = 1'b0;
    load_val = '0;
    model_reset();

    reset_cycles(2);

    // One-shot from 5
    cycle(1, 0, 1, 0, 5);
    for (int i = 0; i < 9; i++) cycle(0, 0, 1, 0, 0);

    // Periodic from 3
    cycle(1, 0, 1, 1, 3);
    for (int i = 0; i < 12; i++) cycle(0, 0, 1, 1, 0);

    // Enable gaps and abort mid-count
    cycle(1, 0, 1, 0, 9);
    for (int i = 0; i < 3; i++) cycle(0, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 0);
    for (int i = 0; i < 2; i++) cycle(0, 0, 1, 0, 0);
    cycle(0, 1, 1, 0, 0);
    for (int i = 0; i < 3; i++) cycle(0, 0, 1, 0, 0);

    // Start+stop together in idle, then restart while running
    cycle(1, 1, 1, 0, 6);
    cycle(0, 0, 1, 0, 0);
    cycle(1, 0, 1, 0, 5);
    for (int i = 0; i < 3; i++) cycle(0, 0, 1, 0, 0);
    cycle(1, 0, 1, 0, 7);
    for (int i = 0; i < 3; i++) cycle(0, 0, 1, 0, 0);

    // Zero load in periodic mode pulses tc every enabled cycle
    cycle(1, 0, 1, 1, 0);
    for (int i = 0; i < 4; i++) cycle(0, 0, 1, 1, 0);
    cycle(0, 1, 0, 0, 0);

    // Full-range period, then reset at count 8
    cycle(1, 0, 1, 1, 15);
    for (int i = 0; i < 23; i++) cycle(0, 0, 1, 1, 0);
    reset_cycles(1);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        reset_cycles(int'($urandom_range(1, 2)));
      end else begin
        cycle(1'($urandom_range(0, 15) == 0),
              1'($urandom_range(0, 31) == 0),
              1'($urandom_range(0, 3) != 0),
              1'($urandom_range(0, 1)),
              $urandom_range(0, 15));
      end
    end

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      n_total++;
      $display("FAIL drain: %0d predictions left, expected 0", exp_q.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
